// File: rtl/bresenham_stream.sv
// Streaming Bresenham line rasteriser: accepts two endpoints and emits every
// pixel of the line, endpoints included, as a valid/ready stream. The whole
// block advances only on cycles where clk_en is high.
module bresenham_stream #(
  parameter int unsigned WIDTH = 10
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             clk_en,
  input  logic             start,
  input  logic [WIDTH-1:0] x0,
  input  logic [WIDTH-1:0] y0,
  input  logic [WIDTH-1:0] x1,
  input  logic [WIDTH-1:0] y1,
  output logic [WIDTH-1:0] x,
  output logic [WIDTH-1:0] y,
  output logic             pix_valid,
  input  logic             pix_ready,
  output logic             busy,
  output logic             done
);

  // err carries two extra bits of headroom; e2 = 2*err needs one more
  localparam int unsigned EW = WIDTH + 2;
  localparam int unsigned PW = WIDTH + 3;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SETUP  = 2'd1,
    S_DRAW   = 2'd2,
    S_FINISH = 2'd3
  } state_t;

  state_t            state_q, state_d;
  logic [WIDTH-1:0]  xs_q, xs_d, ys_q, ys_d;
  logic [WIDTH-1:0]  xe_q, xe_d, ye_q, ye_d;
  logic [WIDTH-1:0]  dx_q, dx_d, ady_q, ady_d;
  logic              sx_neg_q, sx_neg_d, sy_neg_q, sy_neg_d;
  logic signed [EW-1:0] err_q, err_d;
  logic [WIDTH-1:0]  x_q, x_d, y_q, y_d;
  logic              pix_valid_q, pix_valid_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;

  logic [WIDTH-1:0]     adx_c, ady_c;
  logic signed [PW-1:0] e2, dx_s, ndy_s, err_sum;
  logic                 step_x, step_y, hs, at_end;

  // State and datapath registers; everything holds while clk_en is low
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q     <= S_IDLE;
      xs_q        <= '0;
      ys_q        <= '0;
      xe_q        <= '0;
      ye_q        <= '0;
      dx_q        <= '0;
      ady_q       <= '0;
      sx_neg_q    <= 1'b0;
      sy_neg_q    <= 1'b0;
      err_q       <= '0;
      x_q         <= '0;
      y_q         <= '0;
      pix_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else if (clk_en) begin
      state_q     <= state_d;
      xs_q        <= xs_d;
      ys_q        <= ys_d;
      xe_q        <= xe_d;
      ye_q        <= ye_d;
      dx_q        <= dx_d;
      ady_q       <= ady_d;
      sx_neg_q    <= sx_neg_d;
      sy_neg_q    <= sy_neg_d;
      err_q       <= err_d;
      x_q         <= x_d;
      y_q         <= y_d;
      pix_valid_q <= pix_valid_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  // Bresenham step decision and error update from the current err
  always_comb begin
    adx_c   = (xs_q < xe_q) ? (xe_q - xs_q) : (xs_q - xe_q);
    ady_c   = (ys_q < ye_q) ? (ye_q - ys_q) : (ys_q - ye_q);
    e2      = $signed({err_q, 1'b0});
    dx_s    = $signed({3'b000, dx_q});
    ndy_s   = -$signed({3'b000, ady_q});
    step_x  = (e2 >= ndy_s);
    step_y  = (e2 <= dx_s);
    err_sum = $signed({err_q[EW-1], err_q});
    if (step_x) err_sum = err_sum + ndy_s;
    if (step_y) err_sum = err_sum + dx_s;
    hs      = pix_valid_q & pix_ready;
    at_end  = (x_q == xe_q) && (y_q == ye_q);
  end

  // Next-state and register updates
  always_comb begin
    state_d     = state_q;
    xs_d        = xs_q;
    ys_d        = ys_q;
    xe_d        = xe_q;
    ye_d        = ye_q;
    dx_d        = dx_q;
    ady_d       = ady_q;
    sx_neg_d    = sx_neg_q;
    sy_neg_d    = sy_neg_q;
    err_d       = err_q;
    x_d         = x_q;
    y_d         = y_q;
    pix_valid_d = pix_valid_q;
    busy_d      = busy_q;
    done_d      = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          xs_d    = x0;
          ys_d    = y0;
          xe_d    = x1;
          ye_d    = y1;
          busy_d  = 1'b1;
          state_d = S_SETUP;
        end
      end
      S_SETUP: begin
        dx_d        = adx_c;
        ady_d       = ady_c;
        sx_neg_d    = !(xs_q < xe_q);
        sy_neg_d    = !(ys_q < ye_q);
        err_d       = $signed(EW'(adx_c) - EW'(ady_c));
        x_d         = xs_q;
        y_d         = ys_q;
        pix_valid_d = 1'b1;
        state_d     = S_DRAW;
      end
      S_DRAW: begin
        if (hs) begin
          if (at_end) begin
            pix_valid_d = 1'b0;
            busy_d      = 1'b0;
            done_d      = 1'b1;
            state_d     = S_FINISH;
          end else begin
            if (step_x) x_d = sx_neg_q ? (x_q - WIDTH'(1)) : (x_q + WIDTH'(1));
            if (step_y) y_d = sy_neg_q ? (y_q - WIDTH'(1)) : (y_q + WIDTH'(1));
            err_d = $signed(err_sum[EW-1:0]);
          end
        end
      end
      S_FINISH: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign x         = x_q;
  assign y         = y_q;
  assign pix_valid = pix_valid_q;
  assign busy      = busy_q;
  assign done      = done_q;

endmodule
